fpu_arbiter: RTL and testbench
==============================

# fpu_arbiter

Sequencing and sharing controller for the single-precision FPU datapath. Two requesters (e.g. an integer-core coprocessor port and a DMA/vector engine) submit operations over valid/ready handshakes. The block grants them round-robin, holds the granted operands stable on the combinational FPU core's inputs for a fixed multicycle settle window, then captures the core's result and flags. It returns them on a single backpressurable response channel tagged with the requester ID.

## Interface
Parameters:
- FORMAT_LENGTH, 32: operand/result width.
- SETTLE_CYCLES, 2: cycles the core inputs are held before the result is sampled; legal range 1..15; 0 is an elaboration error.

Ports (clock and reset first):
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  reset; one clock, synchronous and active-high.
- req0_valid / req1_valid  in  1  requester has an operation.
- req0_ready / req1_ready  out  1  grant; transfer occurs when valid&&ready.
- reqN_op_a, reqN_op_b  in  FORMAT_LENGTH  operands (N=0,1).
- reqN_operation  in  3  000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 ROOT, 101-111 illegal.
- reqN_n_th  in  2  root order, used only for ROOT.
- fpu_op_a, fpu_op_b  out  FORMAT_LENGTH  registered core operands.
- fpu_operation  out  3  and fpu_n_th  out  2: registered core controls.
- fpu_result  in  FORMAT_LENGTH; fpu_overflow, fpu_underflow, fpu_root_error  in  1 each: core outputs.
- rsp_valid  out  1; rsp_ready  in  1: response handshake.
- rsp_id  out  1  requester index.
- rsp_result  out  FORMAT_LENGTH.
- rsp_flags  out  4  {illegal, root_error, underflow, overflow}.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: arbitrate among asserted valids. With one valid, grant it. With both valid, grant the requester that is not last_grant. reqN_ready = (state==IDLE) && grant==N, combinational from valid and last_grant. The non-granted ready is 0.
- On accept: register op_a, op_b, operation, n_th onto fpu_* and record id. last_grant <= id.
  - Legal opcode: go to EXEC, with settle counter <= SETTLE_CYCLES-1.
  - Illegal opcode: go directly to RESP with rsp_result=0, rsp_flags=4'b1000.
- EXEC: fpu_* held constant; counter decrements each cycle. In the cycle counter==0, sample fpu_result and the three flags into rsp registers, with illegal=0, then go to RESP.
- RESP: rsp_valid=1. All rsp_* are stable until rsp_valid&&rsp_ready, then go to IDLE. No request is accepted in RESP or EXEC.
- fpu_* keep the last accepted op after completion; they change only on a new accept.
- Flags are passed through unmodified. Only the core's overflow, underflow and root_error are reported; the block does no arithmetic.

## Timing
- Reset values: state=IDLE, last_grant=1 (req0 wins first contention), counter=0, all fpu_* = 0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0, busy=0, both readys follow IDLE arbitration.
- Accept on edge of cycle k.
  - Legal op: EXEC occupies cycles k+1..k+SETTLE_CYCLES; rsp_valid first high in cycle k+SETTLE_CYCLES+1.
  - Illegal op: rsp_valid high in cycle k+1.
- With rsp_ready held 1, the minimum initiation interval is SETTLE_CYCLES+2 cycles (EXEC + RESP + IDLE).
- Backpressure: rsp_ready=0 keeps state in RESP indefinitely with all outputs frozen.
- Simultaneous valids at the first IDLE cycle after a response: round-robin applies, and the previous winner loses.
- A valid deasserted before being granted is never accepted, with no residue. A valid held while the other requester is served is granted next.
- rst asserted mid-EXEC or RESP: the in-flight op is dropped and no response is issued. The next cycle shows reset values.

## Test plan
- ADD, SETTLE_CYCLES=2: req0 op_a=0x3F800000, op_b=0x40000000, accepted cycle 0. Required: rsp_valid first at cycle 3, rsp_result=0x40400000, rsp_id=0, rsp_flags=0.
- Contention: both valid continuously from reset with MUL 0x40400000 × 0xC0000000. Required: grants alternate 0,1,0,1; each rsp_result=0xC0C00000; rsp_id alternates starting at 0.
- Backpressure: hold rsp_ready=0 for 10 cycles during RESP. Required: rsp_* constant, both readys 0, busy=1. Release, then IDLE the next cycle.
- ROOT error: req1 operation=100, op_a=0xC0800000, n_th=2'b01. Required: rsp_flags[2]=1, rsp_id=1.
- Illegal op 3'b111: required response one cycle after accept, rsp_result=0, rsp_flags=4'b1000, fpu inputs not held for a settle window.
- Reset mid-EXEC: assert rst in cycle 1 of EXEC. Required: rsp_valid never rises for that op, all outputs at reset values next cycle, a fresh request completes normally.

Source files
------------

// File: rtl/fpu_arbiter.sv
// rtl/fpu_arbiter.sv - round-robin sharing controller for a multicycle combinational FPU core
module fpu_arbiter #(
    parameter int FORMAT_LENGTH = 32,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [FORMAT_LENGTH-1:0] req0_op_a,
    input  logic [FORMAT_LENGTH-1:0] req0_op_b,
    input  logic [2:0]               req0_operation,
    input  logic [1:0]               req0_n_th,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [FORMAT_LENGTH-1:0] req1_op_a,
    input  logic [FORMAT_LENGTH-1:0] req1_op_b,
    input  logic [2:0]               req1_operation,
    input  logic [1:0]               req1_n_th,
    output logic [FORMAT_LENGTH-1:0] fpu_op_a,
    output logic [FORMAT_LENGTH-1:0] fpu_op_b,
    output logic [2:0]               fpu_operation,
    output logic [1:0]               fpu_n_th,
    input  logic [FORMAT_LENGTH-1:0] fpu_result,
    input  logic                     fpu_overflow,
    input  logic                     fpu_underflow,
    input  logic                     fpu_root_error,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_id,
    output logic [FORMAT_LENGTH-1:0] rsp_result,
    output logic [3:0]               rsp_flags,
    output logic                     busy
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_settle_range
        $error("fpu_arbiter: SETTLE_CYCLES must be within 1..15");
    end

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

    logic [1:0]               state;
    logic                     last_grant;
    logic [3:0]               counter;
    logic                     accept;
    logic                     illegal;
    logic [FORMAT_LENGTH-1:0] sel_a;
    logic [FORMAT_LENGTH-1:0] sel_b;
    logic [2:0]               sel_op;
    logic [1:0]               sel_n;

    // Under contention the requester that did not win last time gets the grant.
    assign req0_ready = (state == ST_IDLE) && req0_valid && (!req1_valid || last_grant);
    assign req1_ready = (state == ST_IDLE) && req1_valid && (!req0_valid || !last_grant);
    assign accept     = req0_ready || req1_ready;

    assign sel_a   = req1_ready ? req1_op_a      : req0_op_a;
    assign sel_b   = req1_ready ? req1_op_b      : req0_op_b;
    assign sel_op  = req1_ready ? req1_operation : req0_operation;
    assign sel_n   = req1_ready ? req1_n_th      : req0_n_th;
    assign illegal = sel_op > 3'd4;

    assign rsp_valid = (state == ST_RESP);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            last_grant    <= 1'b1;
            counter       <= 4'd0;
            fpu_op_a      <= '0;
            fpu_op_b      <= '0;
            fpu_operation <= 3'd0;
            fpu_n_th      <= 2'd0;
            rsp_id        <= 1'b0;
            rsp_result    <= '0;
            rsp_flags     <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        fpu_op_a      <= sel_a;
                        fpu_op_b      <= sel_b;
                        fpu_operation <= sel_op;
                        fpu_n_th      <= sel_n;
                        rsp_id        <= req1_ready;
                        last_grant    <= req1_ready;
                        if (illegal) begin
                            rsp_result <= '0;
                            rsp_flags  <= 4'b1000;
                            state      <= ST_RESP;
                        end else begin
                            counter <= SETTLE_INIT;
                            state   <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    // Core inputs have been stable for SETTLE_CYCLES cycles when counter hits 0.
                    if (counter == 4'd0) begin
                        rsp_result <= fpu_result;
                        rsp_flags  <= {1'b0, fpu_root_error, fpu_underflow, fpu_overflow};
                        state      <= ST_RESP;
                    end else begin
                        counter <= counter - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_arbiter.sv
// tb/tb_fpu_arbiter.sv - scoreboard bench for fpu_arbiter with a settle-sensitive core stand-in
module tb_fpu_arbiter;
    localparam int FL = 32;
    localparam int SC = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid, req0_ready, req1_ready;
    logic [FL-1:0] req0_op_a, req0_op_b, req1_op_a, req1_op_b;
    logic [2:0]    req0_operation, req1_operation;
    logic [1:0]    req0_n_th, req1_n_th;
    logic [FL-1:0] fpu_op_a, fpu_op_b, fpu_result;
    logic [2:0]    fpu_operation;
    logic [1:0]    fpu_n_th;
    logic          fpu_overflow, fpu_underflow, fpu_root_error;
    logic          rsp_valid, rsp_ready, rsp_id, busy;
    logic [FL-1:0] rsp_result;
    logic [3:0]    rsp_flags;

    fpu_arbiter #(.FORMAT_LENGTH(FL), .SETTLE_CYCLES(SC)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op_a(req0_op_a),
        .req0_op_b(req0_op_b), .req0_operation(req0_operation), .req0_n_th(req0_n_th),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op_a(req1_op_a),
        .req1_op_b(req1_op_b), .req1_operation(req1_operation), .req1_n_th(req1_n_th),
        .fpu_op_a(fpu_op_a), .fpu_op_b(fpu_op_b), .fpu_operation(fpu_operation),
        .fpu_n_th(fpu_n_th), .fpu_result(fpu_result), .fpu_overflow(fpu_overflow),
        .fpu_underflow(fpu_underflow), .fpu_root_error(fpu_root_error),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // Stand-in core: real answers for the known float cases, a hash otherwise.
    function automatic logic [34:0] core_eval(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] op, input logic [1:0] n);
        logic [31:0] r;
        logic        ov, un, re;
        r = (a * 32'h9E3779B1) ^ {b[15:0], b[31:16]} ^ {27'd0, op, n};
        if (op == 3'd0 && a == 32'h3F800000 && b == 32'h40000000) r = 32'h40400000;
        if (op == 3'd2 && a == 32'h40400000 && b == 32'hC0000000) r = 32'hC0C00000;
        ov = (op == 3'd0 || op == 3'd2) && a[30] && b[30] && r[0];
        un = (op == 3'd3) && b[29] && !a[29];
        re = (op == 3'd4) && a[31];
        return {re, un, ov, r};
    endfunction

    // The core only produces its answer once its inputs have been stable for SC cycles.
    logic [68:0] fpu_prev = '0;
    int          stab = 0;
    logic [34:0] core_out;
    always @(negedge clk) begin
        if ({fpu_op_a, fpu_op_b, fpu_operation, fpu_n_th} != fpu_prev) stab = 1;
        else if (stab < 1000) stab = stab + 1;
        fpu_prev = {fpu_op_a, fpu_op_b, fpu_operation, fpu_n_th};
    end
    always_comb core_out = core_eval(fpu_op_a, fpu_op_b, fpu_operation, fpu_n_th);
    assign fpu_result     = (stab >= SC) ? core_out[31:0] : 32'hDEADBEEF;
    assign fpu_overflow   = (stab >= SC) ? core_out[32] : 1'b1;
    assign fpu_underflow  = (stab >= SC) ? core_out[33] : 1'b1;
    assign fpu_root_error = (stab >= SC) ? core_out[34] : 1'b1;

    typedef struct {
        logic        id;
        logic [31:0] result;
        logic [3:0]  flags;
        int          due;
    } exp_t;

    exp_t        sb[$];
    logic        glog[$];
    bit          m_idle = 1'b1;
    bit          m_last = 1'b1;
    logic [68:0] m_fpu = '0;
    bit          post_reset = 1'b0;
    bit          prev_rv = 1'b0;
    bit          acc0 = 1'b0;
    bit          acc1 = 1'b0;

    always @(negedge clk) begin
        exp_t        e;
        bit          w;
        logic [31:0] a, b;
        logic [2:0]  op;
        logic [1:0]  n;
        logic [34:0] c;
        if (rst) begin
            sb.delete();
            m_idle = 1'b1; m_last = 1'b1; m_fpu = '0;
            post_reset = 1'b1; prev_rv = 1'b0; acc0 = 1'b0; acc1 = 1'b0;
        end else begin
            if (post_reset) begin
                chk("reset_rsp_valid", rsp_valid, 0);
                chk("reset_rsp_id", rsp_id, 0);
                chk("reset_rsp_result", rsp_result, 0);
                chk("reset_rsp_flags", rsp_flags, 0);
                chk("reset_busy", busy, 0);
                post_reset = 1'b0;
            end
            chk("fpu_hold", {fpu_op_a, fpu_op_b, fpu_operation, fpu_n_th}, m_fpu);
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            if (acc0 || acc1) glog.push_back(req1_ready);
            if (m_idle) begin
                chk("idle_busy", busy, 0);
                if (req0_valid || req1_valid) begin
                    w = (req0_valid && req1_valid) ? !m_last : req1_valid;
                    chk("grant_ready0", req0_ready, !w);
                    chk("grant_ready1", req1_ready, w);
                    a  = w ? req1_op_a : req0_op_a;
                    b  = w ? req1_op_b : req0_op_b;
                    op = w ? req1_operation : req0_operation;
                    n  = w ? req1_n_th : req0_n_th;
                    e.id = w;
                    if (op > 3'd4) begin
                        e.result = '0; e.flags = 4'b1000; e.due = cyc + 1;
                    end else begin
                        c = core_eval(a, b, op, n);
                        e.result = c[31:0]; e.flags = {1'b0, c[34:32]}; e.due = cyc + SC + 1;
                    end
                    sb.push_back(e);
                    m_last = w; m_idle = 1'b0; m_fpu = {a, b, op, n};
                end
            end else begin
                chk("busy_high", busy, 1);
                chk("busy_ready0", req0_ready, 0);
                chk("busy_ready1", req1_ready, 0);
            end
            if (sb.size() != 0 && cyc == sb[0].due) chk("rsp_due", rsp_valid, 1);
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", rsp_valid, 0);
                end else begin
                    e = sb[0];
                    if (!prev_rv) chk("rsp_latency", cyc, e.due);
                    chk("rsp_id", rsp_id, e.id);
                    chk("rsp_result", rsp_result, e.result);
                    chk("rsp_flags", rsp_flags, e.flags);
                    if (rsp_ready) begin
                        void'(sb.pop_front());
                        m_idle = 1'b1;
                    end
                end
            end
            prev_rv = rsp_valid && !rsp_ready;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit n, input bit v, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op, input logic [1:0] nth);
        if (n) begin
            req1_valid = v; req1_op_a = a; req1_op_b = b; req1_operation = op; req1_n_th = nth;
        end else begin
            req0_valid = v; req0_op_a = a; req0_op_b = b; req0_operation = op; req0_n_th = nth;
        end
    endtask

    task automatic send(input bit n, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic [1:0] nth);
        int k;
        set_req(n, 1'b1, a, b, op, nth);
        for (k = 0; k < 200; k++) begin
            @(posedge clk);
            if (n ? acc1 : acc0) break;
        end
        #1;
        if (k == 200) chk("send_timeout", 0, 1);
        if (n) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        for (k = 0; k < 300; k++) begin
            @(posedge clk);
            if (sb.size() == 0 && m_idle) break;
        end
        #1;
        if (k == 300) chk("drain_timeout", 0, 1);
    endtask

    function automatic logic [2:0] rand_op();
        if ($urandom_range(0, 7) == 0) return 3'($urandom_range(5, 7));
        return 3'($urandom_range(0, 4));
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int cnt;
        rst = 1'b1; rsp_ready = 1'b1;
        set_req(0, 0, '0, '0, 3'd0, 2'd0);
        set_req(1, 0, '0, '0, 3'd0, 2'd0);
        step(); step();
        rst = 1'b0;
        step();

        // Contention from reset: grants must alternate starting with requester 0.
        glog.delete();
        set_req(0, 1, 32'h40400000, 32'hC0000000, 3'd2, 2'd0);
        set_req(1, 1, 32'h40400000, 32'hC0000000, 3'd2, 2'd0);
        cnt = 0;
        for (int k = 0; k < 200 && cnt < 4; k++) begin
            @(posedge clk);
            if (acc0 || acc1) cnt++;
        end
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_done();
        chk("contention_count", glog.size(), 4);
        for (int i = 0; i < 4 && i < glog.size(); i++) chk("contention_order", glog[i], i % 2);

        send(0, 32'h3F800000, 32'h40000000, 3'd0, 2'd0);
        wait_done();

        // Backpressure with a competing request waiting.
        rsp_ready = 1'b0;
        send(0, 32'h12345678, 32'h0BADF00D, 3'd1, 2'd0);
        set_req(1, 1, 32'h40400000, 32'h3F800000, 3'd3, 2'd0);
        for (int k = 0; k < 50 && !rsp_valid; k++) step();
        repeat (10) step();
        rsp_ready = 1'b1;
        send(1, 32'h40400000, 32'h3F800000, 3'd3, 2'd0);
        wait_done();

        send(1, 32'hC0800000, 32'h00000000, 3'd4, 2'b01);
        wait_done();
        send(0, 32'h3F800000, 32'h3F800000, 3'd7, 2'd0);
        wait_done();

        // Reset during the first EXEC cycle drops the op.
        send(0, 32'h41200000, 32'h40A00000, 3'd2, 2'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (3) step();
        send(1, 32'h3F800000, 32'h40000000, 3'd0, 2'd0);
        wait_done();

        repeat (700) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (acc0) begin
                if ($urandom_range(0, 1) == 0) req0_valid = 1'b0;
                else set_req(0, 1, $urandom, $urandom, rand_op(), 2'($urandom_range(0, 3)));
            end else if (req0_valid && $urandom_range(0, 15) == 0) begin
                req0_valid = 1'b0;
            end else if (!req0_valid && $urandom_range(0, 2) == 0) begin
                set_req(0, 1, $urandom, $urandom, rand_op(), 2'($urandom_range(0, 3)));
            end
            if (acc1) begin
                if ($urandom_range(0, 1) == 0) req1_valid = 1'b0;
                else set_req(1, 1, $urandom, $urandom, rand_op(), 2'($urandom_range(0, 3)));
            end else if (req1_valid && $urandom_range(0, 15) == 0) begin
                req1_valid = 1'b0;
            end else if (!req1_valid && $urandom_range(0, 2) == 0) begin
                set_req(1, 1, $urandom, $urandom, rand_op(), 2'($urandom_range(0, 3)));
            end
            step();
        end

        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        wait_done();
        repeat (3) step();
        chk("final_queue_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
